noc_port_arbiter: RTL and testbench
===================================

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of ap_bus requesters sharing one NoC port (2..8).
REQ-002 Parameter TAG_DEPTH, default 16: maximum outstanding reads (power of 2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_pe_req  input  NUM_REQ  per-requester request, held until granted.
REQ-006 req_wrNotRd  input  NUM_REQ  per-requester direction; 1=write, 0=read.
REQ-007 req_address  input  NUM_REQ*`DATA_AWIDTH  per-requester word address, slice i = requester i.
REQ-008 req_wr_data  input  NUM_REQ*`DATA_DWIDTH  per-requester write data.
REQ-009 req_size  input  NUM_REQ*`DATA_DWIDTH  per-requester burst size, passed through.
REQ-010 req_done  input  NUM_REQ  per-requester ap_done pulse.
REQ-011 req_gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted request.
REQ-012 req_rd_valid  output  NUM_REQ  read-return strobe to owning requester.
REQ-013 req_rd_data  output  `DATA_DWIDTH  read data, shared by all requesters.
REQ-014 pe_req, wrNotRd, address, wr_data, size  output  1,1,`DATA_AWIDTH,`DATA_DWIDTH,`DATA_DWIDTH  registered request to NoC interfacer.
REQ-015 ap_done  output  1  registered single-cycle aggregate done to NoC interfacer.
REQ-016 rd_valid, rd_data  input  1,`DATA_DWIDTH  in-order read return from NoC interfacer.
REQ-017 wr_ready  input  1  NoC back-pressure; 0 blocks writes.
REQ-018 err  output  1  sticky protocol-error flag.

Function
REQ-019 Eligibility: requester i eligible when req_pe_req[i]=1, done_seen[i]=0, state=RUN, and (write: wr_ready=1) or (read: tag count < TAG_DEPTH).
REQ-020 Round-robin: at most one grant per cycle; search starts at pointer rr_ptr; after grant to k, rr_ptr <= (k+1) mod NUM_REQ; no grant leaves rr_ptr unchanged.
REQ-021 Granted request is registered onto pe_req/wrNotRd/address/wr_data/size the next cycle (latency 1); pe_req is 0 in cycles without a grant, other outputs hold.
REQ-022 Requester drops req_pe_req the cycle after req_gnt; arbiter keeps no request state of its own.
REQ-023 Each granted read pushes requester index into tag FIFO in the grant cycle.
REQ-024 rd_valid=1 pops tag FIFO head h; req_rd_valid[h]=1 and req_rd_data=rd_data in the same cycle (combinational return).
REQ-025 Simultaneous push and pop: both performed, count unchanged; push when count=TAG_DEPTH never occurs (REQ-019).
REQ-026 rd_valid with empty tag FIFO: data dropped, no req_rd_valid, err<=1 (sticky until reset).
REQ-027 req_done[i] sets done_seen[i]; further requests from i are ignored (never granted).
REQ-028 States: RUN -> DRAIN when all done_seen set; DRAIN -> DONE when tag count=0 and pe_req=0; DONE holds until reset.
REQ-029 On RUN->DRAIN no grants issue; on DRAIN->DONE ap_done=1 for exactly one cycle.
REQ-030 All-done and last read return in the same cycle: pop applies first, DRAIN entered, DONE follows next cycle.

Reset
REQ-031 rst=0 asynchronously: state=RUN, rr_ptr=0, tag FIFO empty, done_seen=0, err=0, pe_req=0, wrNotRd=0, address=0, wr_data=0, size=0, ap_done=0.
REQ-032 req_gnt and req_rd_valid are 0 while rst=0; reset mid-burst discards outstanding tags without error.

Verification
REQ-033 Requesters 0..3 request writes simultaneously, wr_ready=1 -> grants 0,1,2,3 on consecutive cycles, pe_req high 4 cycles starting 1 cycle later.
REQ-034 Requester 2 write, wr_ready=0 for 5 cycles -> no grant; grant in cycle wr_ready returns to 1.
REQ-035 Reads from 1,3,0 (addresses 0x10,0x20,0x30), returns 0xA,0xB,0xC -> req_rd_valid pulses 1,3,0 carrying 0xA,0xB,0xC.
REQ-036 16 reads outstanding (TAG_DEPTH=16) -> 17th read not granted until one rd_valid; concurrent write still granted.
REQ-037 rd_valid with no outstanding reads -> err=1, stays 1 until rst=0.
REQ-038 All req_done pulsed with 2 reads outstanding -> no new grants; ap_done single pulse one cycle after last return.

Source files
------------

// File: rtl/noc_port_arbiter_if.sv
// Requester-side and NoC-side signal bundle for noc_port_arbiter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface noc_port_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_AWIDTH = 32,
  parameter int unsigned DATA_DWIDTH = 32
);
  logic [NUM_REQ-1:0]             req_pe_req;
  logic [NUM_REQ-1:0]             req_wrNotRd;
  logic [NUM_REQ*DATA_AWIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_DWIDTH-1:0] req_wr_data;
  logic [NUM_REQ*DATA_DWIDTH-1:0] req_size;
  logic [NUM_REQ-1:0]             req_done;
  logic [NUM_REQ-1:0]             req_gnt;
  logic [NUM_REQ-1:0]             req_rd_valid;
  logic [DATA_DWIDTH-1:0]         req_rd_data;

  logic                   pe_req;
  logic                   wrNotRd;
  logic [DATA_AWIDTH-1:0] address;
  logic [DATA_DWIDTH-1:0] wr_data;
  logic [DATA_DWIDTH-1:0] size;
  logic                   ap_done;
  logic                   rd_valid;
  logic [DATA_DWIDTH-1:0] rd_data;
  logic                   wr_ready;
  logic                   err;

  modport slave (
    input  req_pe_req, req_wrNotRd, req_address, req_wr_data, req_size, req_done,
    output req_gnt, req_rd_valid, req_rd_data,
    output pe_req, wrNotRd, address, wr_data, size, ap_done, err,
    input  rd_valid, rd_data, wr_ready
  );

  modport master (
    output req_pe_req, req_wrNotRd, req_address, req_wr_data, req_size, req_done,
    input  req_gnt, req_rd_valid, req_rd_data,
    input  pe_req, wrNotRd, address, wr_data, size, ap_done, err,
    output rd_valid, rd_data, wr_ready
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one NoC port among NUM_REQ ap_bus requesters,
// with an in-order tag FIFO steering read returns back to their owners.
module noc_port_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TAG_DEPTH   = 16,
  parameter int unsigned DATA_AWIDTH = 32,
  parameter int unsigned DATA_DWIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  noc_port_arbiter_if.slave    io_bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_d;
  logic [IdxW-1:0]        r_rr_ptr;
  logic [NUM_REQ-1:0]     r_done_seen;
  logic [IdxW-1:0]        r_tag_mem [TAG_DEPTH];
  logic [PtrW-1:0]        r_wr_ptr;
  logic [PtrW-1:0]        r_rd_ptr;
  logic [CntW-1:0]        r_count;
  logic [CntW-1:0]        w_count_d;
  logic                   r_err;
  logic                   r_pe_req;
  logic                   r_wrNotRd;
  logic [DATA_AWIDTH-1:0] r_address;
  logic [DATA_DWIDTH-1:0] r_wr_data;
  logic [DATA_DWIDTH-1:0] r_size;
  logic                   r_ap_done;
  logic                   w_ap_done_d;

  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_gnt_any;
  logic [IdxW-1:0]        w_gnt_idx;
  logic                   w_sel_wr;
  logic                   w_tags_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_stray_rd;

  assign w_tags_full = (r_count == CntW'(TAG_DEPTH));

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = io_bus.req_pe_req[i] & ~r_done_seen[i] & (r_state == StRun) &
                  (io_bus.req_wrNotRd[i] ? io_bus.wr_ready : ~w_tags_full);
    end
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!w_gnt_any && w_elig[IdxW'((32'(r_rr_ptr) + off) % NUM_REQ)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IdxW'((32'(r_rr_ptr) + off) % NUM_REQ);
      end
    end
  end

  assign w_sel_wr   = io_bus.req_wrNotRd[w_gnt_idx];
  assign w_push     = w_gnt_any & ~w_sel_wr;
  assign w_pop      = io_bus.rd_valid & (r_count != '0);
  assign w_stray_rd = io_bus.rd_valid & (r_count == '0);
  assign w_count_d  = r_count + CntW'(w_push) - CntW'(w_pop);

  always_comb begin
    io_bus.req_gnt = '0;
    if (w_gnt_any && i_rst_n) begin
      io_bus.req_gnt = NUM_REQ'(1) << w_gnt_idx;
    end
  end

  always_comb begin
    io_bus.req_rd_valid = '0;
    if (w_pop && i_rst_n) begin
      io_bus.req_rd_valid = NUM_REQ'(1) << r_tag_mem[r_rd_ptr];
    end
  end

  assign io_bus.req_rd_data = io_bus.rd_data;

  // DRAIN waits for the last read return and for the final request to leave the port.
  always_comb begin
    w_state_d   = r_state;
    w_ap_done_d = 1'b0;
    case (r_state)
      StRun: begin
        if (&r_done_seen) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if ((w_count_d == '0) && !r_pe_req) begin
          w_state_d   = StDone;
          w_ap_done_d = 1'b1;
        end
      end
      StDone:  w_state_d = StDone;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_gnt_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StRun;
      r_rr_ptr    <= '0;
      r_done_seen <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_ap_done   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_done_seen <= r_done_seen | io_bus.req_done;
      r_count     <= w_count_d;
      r_err       <= r_err | w_stray_rd;
      r_ap_done   <= w_ap_done_d;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_gnt_any) begin
        r_rr_ptr <= (w_gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IdxW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pe_req  <= 1'b0;
      r_wrNotRd <= 1'b0;
      r_address <= '0;
      r_wr_data <= '0;
      r_size    <= '0;
    end else begin
      r_pe_req <= w_gnt_any;
      if (w_gnt_any) begin
        r_wrNotRd <= w_sel_wr;
        r_address <= io_bus.req_address[w_gnt_idx*DATA_AWIDTH +: DATA_AWIDTH];
        r_wr_data <= io_bus.req_wr_data[w_gnt_idx*DATA_DWIDTH +: DATA_DWIDTH];
        r_size    <= io_bus.req_size[w_gnt_idx*DATA_DWIDTH +: DATA_DWIDTH];
      end
    end
  end

  assign io_bus.pe_req  = r_pe_req;
  assign io_bus.wrNotRd = r_wrNotRd;
  assign io_bus.address = r_address;
  assign io_bus.wr_data = r_wr_data;
  assign io_bus.size    = r_size;
  assign io_bus.ap_done = r_ap_done;
  assign io_bus.err     = r_err;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for the grant/return/done scenarios.
module tb_noc_port_arbiter;

  localparam int N  = 4;
  localparam int TD = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_port_arbiter_if #(.NUM_REQ(N), .DATA_AWIDTH(AW), .DATA_DWIDTH(DW)) bus ();

  noc_port_arbiter #(
    .NUM_REQ    (N),
    .TAG_DEPTH  (TD),
    .DATA_AWIDTH(AW),
    .DATA_DWIDTH(DW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int            gnt_idx_log[$];
  int            gnt_cyc_log[$];
  int            pe_cyc_log[$];
  int            rd_idx_log[$];
  int            rd_cyc_log[$];
  logic [DW-1:0] rd_data_log[$];
  int            ap_cyc_log[$];

  // Reference model: state 0=RUN 1=DRAIN 2=DONE
  int            m_q[$];
  int            m_ptr;
  bit            m_done[N];
  int            m_state;
  bit            m_err, m_pe, m_wr, m_ap;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_size;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    int g;
    int k;
    bit old_pe;
    bit all_done;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rdv;
    cyc++;
    if (!rst_n) begin
      chk("rst_gnt", bus.req_gnt, 0);
      chk("rst_rd_valid", bus.req_rd_valid, 0);
      chk("rst_pe_req", bus.pe_req, 0);
      chk("rst_wrNotRd", bus.wrNotRd, 0);
      chk("rst_address", bus.address, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_size", bus.size, 0);
      chk("rst_ap_done", bus.ap_done, 0);
      chk("rst_err", bus.err, 0);
      m_q.delete();
      m_ptr = 0;
      for (int i = 0; i < N; i++) m_done[i] = 1'b0;
      m_state = 0;
      m_err = 0; m_pe = 0; m_wr = 0; m_ap = 0;
      m_addr = '0; m_wdata = '0; m_size = '0;
    end else begin
      g = -1;
      if (m_state == 0) begin
        for (int off = 0; off < N; off++) begin
          k = (m_ptr + off) % N;
          if (g < 0 && bus.req_pe_req[k] && !m_done[k] &&
              (bus.req_wrNotRd[k] ? bus.wr_ready : (m_q.size() < TD))) g = k;
        end
      end
      exp_gnt = (g >= 0) ? (N'(1) << g) : '0;
      exp_rdv = (bus.rd_valid && m_q.size() > 0) ? (N'(1) << m_q[0]) : '0;
      chk("gnt", bus.req_gnt, exp_gnt);
      chk("rd_valid", bus.req_rd_valid, exp_rdv);
      if (exp_rdv != '0) chk("rd_data", bus.req_rd_data, bus.rd_data);
      chk("pe_req", bus.pe_req, m_pe);
      chk("wrNotRd", bus.wrNotRd, m_wr);
      chk("address", bus.address, m_addr);
      chk("wr_data", bus.wr_data, m_wdata);
      chk("size", bus.size, m_size);
      chk("ap_done", bus.ap_done, m_ap);
      chk("err", bus.err, m_err);

      for (int i = 0; i < N; i++) begin
        if (bus.req_gnt[i]) begin gnt_idx_log.push_back(i); gnt_cyc_log.push_back(cyc); end
        if (bus.req_rd_valid[i]) begin
          rd_idx_log.push_back(i); rd_cyc_log.push_back(cyc); rd_data_log.push_back(bus.req_rd_data);
        end
      end
      if (bus.pe_req) pe_cyc_log.push_back(cyc);
      if (bus.ap_done) ap_cyc_log.push_back(cyc);

      old_pe = m_pe;
      all_done = 1'b1;
      for (int i = 0; i < N; i++) if (!m_done[i]) all_done = 1'b0;
      if (bus.rd_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (g >= 0) begin
        if (!bus.req_wrNotRd[g]) m_q.push_back(g);
        m_ptr   = (g + 1) % N;
        m_wr    = bus.req_wrNotRd[g];
        m_addr  = bus.req_address[g*AW +: AW];
        m_wdata = bus.req_wr_data[g*DW +: DW];
        m_size  = bus.req_size[g*DW +: DW];
      end
      m_pe = (g >= 0);
      m_ap = 1'b0;
      if (m_state == 0 && all_done) m_state = 1;
      else if (m_state == 1 && m_q.size() == 0 && !old_pe) begin
        m_state = 2;
        m_ap    = 1'b1;
      end
      for (int i = 0; i < N; i++) if (bus.req_done[i]) m_done[i] = 1'b1;
    end
  end

  // One clock; a granted requester drops its request afterwards.
  task automatic step();
    logic [N-1:0] g;
    @(negedge clk);
    g = bus.req_gnt;
    @(posedge clk);
    #1;
    bus.req_pe_req = bus.req_pe_req & ~g;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_pe_req[i]        = 1'b1;
    bus.req_wrNotRd[i]       = wr;
    bus.req_address[i*AW +: AW] = a;
    bus.req_wr_data[i*DW +: DW] = d;
    bus.req_size[i*DW +: DW]    = DW'(32'h40 + i);
  endtask

  task automatic wait_gnt(input int i, input string name);
    for (int t = 0; t < 40 && bus.req_pe_req[i]; t++) step();
    chk(name, bus.req_pe_req[i], 0);
  endtask

  task automatic clear_logs();
    gnt_idx_log.delete(); gnt_cyc_log.delete(); pe_cyc_log.delete();
    rd_idx_log.delete(); rd_cyc_log.delete(); rd_data_log.delete(); ap_cyc_log.delete();
  endtask

  task automatic pulse_rd(input logic [DW-1:0] d);
    bus.rd_valid = 1'b1;
    bus.rd_data  = d;
    step();
    bus.rd_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ret_vals[3];
    int            ret_idx[3];
    ret_vals = '{32'hA, 32'hB, 32'hC};
    ret_idx  = '{1, 3, 0};
    bus.req_pe_req = '0; bus.req_wrNotRd = '0; bus.req_address = '0;
    bus.req_wr_data = '0; bus.req_size = '0; bus.req_done = '0;
    bus.rd_valid = 1'b0; bus.rd_data = '0; bus.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Four simultaneous writes
    clear_logs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32'h100 + i), DW'(32'hD0 + i));
    repeat (6) step();
    chk("t1_ngnt", gnt_idx_log.size(), 4);
    chk("t1_pe_cnt", pe_cyc_log.size(), 4);
    if (gnt_idx_log.size() == 4 && pe_cyc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t1_order", gnt_idx_log[i], i);
      chk("t1_consec", gnt_cyc_log[3] - gnt_cyc_log[0], 3);
      chk("t1_pe_start", pe_cyc_log[0], gnt_cyc_log[0] + 1);
    end

    // Write held off by back-pressure
    clear_logs();
    bus.wr_ready = 1'b0;
    set_req(2, 1'b1, 32'h200, 32'hBEEF);
    repeat (5) step();
    chk("t2_blocked", gnt_idx_log.size(), 0);
    bus.wr_ready = 1'b1;
    step();
    chk("t2_ngnt", gnt_idx_log.size(), 1);
    if (gnt_idx_log.size() == 1) chk("t2_idx", gnt_idx_log[0], 2);
    step();

    // Reads from 1,3,0 returned in order
    clear_logs();
    set_req(1, 1'b0, 32'h10, 32'h0); wait_gnt(1, "t3_gnt1");
    set_req(3, 1'b0, 32'h20, 32'h0); wait_gnt(3, "t3_gnt3");
    set_req(0, 1'b0, 32'h30, 32'h0); wait_gnt(0, "t3_gnt0");
    step();
    for (int j = 0; j < 3; j++) pulse_rd(ret_vals[j]);
    step();
    chk("t3_nret", rd_idx_log.size(), 3);
    if (rd_idx_log.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        chk("t3_ret_idx", rd_idx_log[j], ret_idx[j]);
        chk("t3_ret_data", rd_data_log[j], ret_vals[j]);
      end
    end

    // Reset with a read outstanding, then a stray return sets sticky err
    set_req(1, 1'b0, 32'h40, 32'h0); wait_gnt(1, "t4_gnt1");
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    clear_logs();
    pulse_rd(32'h99);
    repeat (3) step();
    chk("t4_err_set", bus.err, 1);
    chk("t4_no_ret", rd_idx_log.size(), 0);
    rst_n = 1'b0;
    step();
    chk("t4_err_clr", bus.err, 0);
    rst_n = 1'b1;
    step();

    // Tag FIFO full: 17th read stalls, write still granted
    for (int t = 0; t < TD; t++) begin
      set_req(t % N, 1'b0, AW'(32'h1000 + t), '0);
      wait_gnt(t % N, "t5_fill");
    end
    clear_logs();
    set_req(1, 1'b0, 32'h2000, '0);
    set_req(2, 1'b1, 32'h3000, 32'h55);
    repeat (3) step();
    chk("t5_ngnt", gnt_idx_log.size(), 1);
    if (gnt_idx_log.size() == 1) chk("t5_wr_gnt", gnt_idx_log[0], 2);
    chk("t5_rd_held", bus.req_pe_req[1], 1);
    pulse_rd(32'h77);
    wait_gnt(1, "t5_rd_after_pop");
    bus.rd_valid = 1'b1;
    for (int t = 0; t < TD; t++) begin
      bus.rd_data = DW'(t);
      step();
    end
    bus.rd_valid = 1'b0;
    step();
    chk("t5_nret", rd_idx_log.size(), TD + 1);
    if (rd_idx_log.size() > 0) chk("t5_head", rd_idx_log[0], 0);
    chk("t5_no_err", bus.err, 0);

    // All done with two reads outstanding
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    set_req(0, 1'b0, 32'h500, '0); wait_gnt(0, "t6_gnt0");
    set_req(1, 1'b0, 32'h600, '0); wait_gnt(1, "t6_gnt1");
    bus.req_done = '1;
    step();
    bus.req_done = '0;
    set_req(2, 1'b1, 32'h700, 32'h9);
    set_req(3, 1'b0, 32'h800, '0);
    repeat (4) step();
    chk("t6_no_new_gnt", gnt_idx_log.size(), 2);
    chk("t6_ap_early", ap_cyc_log.size(), 0);
    pulse_rd(32'hE1);
    pulse_rd(32'hE2);
    repeat (4) step();
    chk("t6_ap_cnt", ap_cyc_log.size(), 1);
    if (ap_cyc_log.size() == 1 && rd_cyc_log.size() == 2)
      chk("t6_ap_cyc", ap_cyc_log[0], rd_cyc_log[1] + 1);
    bus.req_pe_req = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
